// File: rtl/psum_bm_if.sv
// Handshake/bus bundle between the PE engine (master) and the psum buffer manager (slave).
// Signal names match the original flat port list.
interface psum_bm_if #(
  parameter int W_PSUM     = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  i_req_psum;
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic                  i_rd_zero;
  logic [W_PSUM-1:0]     o_psum_data;
  logic                  o_psum_vld;
  logic                  i_psum_we;
  logic [ADDR_WIDTH-1:0] i_psum_addr;
  logic [W_PSUM-1:0]     i_psum_wdata;
  logic                  i_drain_start;
  logic [ADDR_WIDTH:0]   i_drain_len;
  logic                  o_drain_vld;
  logic [ADDR_WIDTH-1:0] o_drain_addr;
  logic [W_PSUM-1:0]     o_drain_data;
  logic                  i_drain_ready;
  logic                  o_drain_done;
  logic                  o_busy;
  logic                  o_err;

  modport master (
    output i_req_psum, i_rd_addr, i_rd_zero, i_psum_we, i_psum_addr, i_psum_wdata,
           i_drain_start, i_drain_len, i_drain_ready,
    input  o_psum_data, o_psum_vld, o_drain_vld, o_drain_addr, o_drain_data,
           o_drain_done, o_busy, o_err
  );

  modport slave (
    input  i_req_psum, i_rd_addr, i_rd_zero, i_psum_we, i_psum_addr, i_psum_wdata,
           i_drain_start, i_drain_len, i_drain_ready,
    output o_psum_data, o_psum_vld, o_drain_vld, o_drain_addr, o_drain_data,
           o_drain_done, o_busy, o_err
  );
endinterface

// File: rtl/psum_bm.sv
// Partial-sum buffer manager: fixed-latency PE read/write port plus a draining stream port.
// Optional write-to-read forwarding is enabled by defining PSUM_FWD_EN.
module psum_bm #(
  parameter int W_PSUM     = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int BM_DELAY   = 2
) (
  input logic      clk,
  input logic      rstn,
  psum_bm_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef PSUM_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t state_q, state_d;

  // storage
  logic [W_PSUM-1:0]     mem [DEPTH];
  logic [W_PSUM-1:0]     ram_q;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [W_PSUM-1:0]     mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_raddr;

  // PE read pipeline; stage 0 holds the RAM read, the rest hold data
  logic [BM_DELAY-1:0]   p_vld;
  logic [BM_DELAY-1:0]   p_zero;
  logic [ADDR_WIDTH-1:0] p_addr [BM_DELAY];
  logic [W_PSUM-1:0]     p_data [BM_DELAY];
  logic                  p_hit0;
  logic [W_PSUM-1:0]     stage_data [BM_DELAY];

  // drain machinery
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH:0]   hs_left;
  logic                  rd_inflight;
  logic [ADDR_WIDTH-1:0] rd_inflight_addr;
  logic [1:0]            fifo_cnt;
  logic [ADDR_WIDTH-1:0] f0_addr, f1_addr;
  logic [W_PSUM-1:0]     f0_data, f1_data;
  logic                  done_q;
  logic                  err_q;

  logic                  pe_rd;
  logic                  issue;
  logic                  pop;
  logic                  done_d;
  logic                  err_set;
  logic                  start_ok;
  logic [2:0]            occ;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pe_rd     = 1'b0;
    issue     = 1'b0;
    pop       = 1'b0;
    done_d    = 1'b0;
    err_set   = 1'b0;
    start_ok  = 1'b0;
    occ       = '0;
    mem_we    = 1'b0;
    mem_waddr = bus.i_psum_addr;
    mem_wdata = bus.i_psum_wdata;
    mem_raddr = bus.i_rd_addr;
    case (state_q)
      S_IDLE: begin
        pe_rd  = bus.i_req_psum;
        mem_we = bus.i_psum_we;
        if (bus.i_drain_start) begin
          if (bus.i_drain_len == '0) begin
            done_d = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        err_set   = bus.i_req_psum | bus.i_psum_we;
        pop       = (fifo_cnt != 2'd0) && bus.i_drain_ready;
        // FIFO slots still spoken for after this cycle's pop, counting the read in flight
        occ       = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
        issue     = (issue_cnt != len_q) && (occ < 3'd2);
        mem_raddr = issue_cnt[ADDR_WIDTH-1:0];
        // Clearing at the handshake keeps undelivered words intact if a drain is aborted by reset
        mem_we    = pop;
        mem_waddr = f0_addr;
        mem_wdata = '0;
        if (pop && hs_left == (ADDR_WIDTH+1)'(1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    ram_q <= mem[mem_raddr];
  end

  always_comb begin
    stage_data[0] = p_hit0 ? p_data[0] : ram_q;
    for (int unsigned k = 1; k < BM_DELAY; k++) stage_data[k] = p_data[k];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_vld  <= '0;
      p_zero <= '0;
      p_hit0 <= 1'b0;
      for (int unsigned k = 0; k < BM_DELAY; k++) begin
        p_addr[k] <= '0;
        p_data[k] <= '0;
      end
    end else begin
      p_vld[0]  <= pe_rd;
      p_zero[0] <= bus.i_rd_zero;
      p_addr[0] <= bus.i_rd_addr;
      p_hit0    <= FWD_EN && mem_we && (mem_waddr == bus.i_rd_addr);
      p_data[0] <= mem_wdata;
      for (int unsigned k = 1; k < BM_DELAY; k++) begin
        p_vld[k]  <= p_vld[k-1];
        p_zero[k] <= p_zero[k-1];
        p_addr[k] <= p_addr[k-1];
        p_data[k] <= (FWD_EN && mem_we && (mem_waddr == p_addr[k-1])) ? mem_wdata
                                                                      : stage_data[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q            <= '0;
      issue_cnt        <= '0;
      hs_left          <= '0;
      rd_inflight      <= 1'b0;
      rd_inflight_addr <= '0;
      fifo_cnt         <= '0;
      f0_addr          <= '0;
      f1_addr          <= '0;
      f0_data          <= '0;
      f1_data          <= '0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q     <= bus.i_drain_len;
        hs_left   <= bus.i_drain_len;
        issue_cnt <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        if (pop)   hs_left   <= hs_left - 1'b1;
      end
      rd_inflight      <= issue;
      rd_inflight_addr <= issue_cnt[ADDR_WIDTH-1:0];
      case ({rd_inflight, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            f0_addr <= rd_inflight_addr;
            f0_data <= ram_q;
          end else begin
            f1_addr <= rd_inflight_addr;
            f1_data <= ram_q;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          f0_addr  <= f1_addr;
          f0_data  <= f1_data;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            f0_addr <= rd_inflight_addr;
            f0_data <= ram_q;
          end else begin
            f0_addr <= f1_addr;
            f0_data <= f1_data;
            f1_addr <= rd_inflight_addr;
            f1_data <= ram_q;
          end
        end
        default: ;
      endcase
      done_q <= done_d;
      err_q  <= err_q | err_set;
    end
  end

  assign bus.o_psum_vld   = p_vld[BM_DELAY-1];
  assign bus.o_psum_data  = (p_vld[BM_DELAY-1] && !p_zero[BM_DELAY-1]) ? stage_data[BM_DELAY-1]
                                                                        : '0;
  assign bus.o_drain_vld  = (fifo_cnt != 2'd0);
  assign bus.o_drain_addr = f0_addr;
  assign bus.o_drain_data = f0_data;
  assign bus.o_drain_done = done_q;
  assign bus.o_busy       = (state_q == S_DRAIN);
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_psum_bm.sv
// Directed bench for psum_bm: read latency, zero qualifier, same-edge hazard, drain, abort.
module tb_psum_bm;
  localparam int W  = 32;
  localparam int AW = 12;
  localparam int D  = 2;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  psum_bm_if #(.W_PSUM(W), .ADDR_WIDTH(AW)) bus ();

  psum_bm #(.W_PSUM(W), .ADDR_WIDTH(AW), .BM_DELAY(D)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_req_psum    = 1'b0;
    bus.i_rd_addr     = '0;
    bus.i_rd_zero     = 1'b0;
    bus.i_psum_we     = 1'b0;
    bus.i_psum_addr   = '0;
    bus.i_psum_wdata  = '0;
    bus.i_drain_start = 1'b0;
    bus.i_drain_len   = '0;
    bus.i_drain_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psum_data"},  bus.o_psum_data,  0);
    check({tag, "_psum_vld"},   bus.o_psum_vld,   0);
    check({tag, "_drain_vld"},  bus.o_drain_vld,  0);
    check({tag, "_drain_addr"}, bus.o_drain_addr, 0);
    check({tag, "_drain_data"}, bus.o_drain_data, 0);
    check({tag, "_drain_done"}, bus.o_drain_done, 0);
    check({tag, "_busy"},       bus.o_busy,       0);
    check({tag, "_err"},        bus.o_err,        0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    bus.i_psum_we    = 1'b1;
    bus.i_psum_addr  = a;
    bus.i_psum_wdata = d;
    tick();
    bus.i_psum_we    = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic z, input logic [W-1:0] exp,
                    input string tag);
    bus.i_req_psum = 1'b1;
    bus.i_rd_addr  = a;
    bus.i_rd_zero  = z;
    for (int k = 1; k <= D; k++) begin
      tick();
      bus.i_req_psum = 1'b0;
      bus.i_rd_zero  = 1'b0;
      if (k < D) check({tag, "_early"}, bus.o_psum_vld, 0);
    end
    check({tag, "_vld"},  bus.o_psum_vld, 1);
    check({tag, "_data"}, bus.o_psum_data, exp);
  endtask

  initial begin
    int               idx, dones, cyc, hs;
    logic             rdy, stall_prev, pe_seen;
    logic [AW-1:0]    prev_addr;
    logic [W-1:0]     prev_data;

    idle_inputs();
    rstn = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // basic latency and zero qualifier
    wr(12'd5, 32'h1234);
    repeat (3) tick();
    rd(12'd5, 1'b0, 32'h1234, "rd5");
    rd(12'd5, 1'b1, 32'h0,    "rd5_zero");

    // same-edge write and read to addr 7
    wr(12'd7, 32'h11);
    repeat (3) tick();
    bus.i_psum_we    = 1'b1;
    bus.i_psum_addr  = 12'd7;
    bus.i_psum_wdata = 32'hAA;
    bus.i_req_psum   = 1'b1;
    bus.i_rd_addr    = 12'd7;
    for (int k = 1; k <= D; k++) begin
      tick();
      bus.i_psum_we  = 1'b0;
      bus.i_req_psum = 1'b0;
    end
    check("hazard_vld", bus.o_psum_vld, 1);
`ifdef PSUM_FWD_EN
    check("hazard_data", bus.o_psum_data, 32'hAA);
`else
    check("hazard_data", bus.o_psum_data, 32'h11);
`endif
    repeat (3) tick();
    rd(12'd7, 1'b0, 32'hAA, "rd7_after");

    // back-to-back requests
    bus.i_req_psum = 1'b1;
    bus.i_rd_addr  = 12'd5;
    tick();
    bus.i_rd_addr  = 12'd7;
    repeat (D - 1) tick();
    check("b2b_vld0",  bus.o_psum_vld, 1);
    check("b2b_data0", bus.o_psum_data, 32'h1234);
    bus.i_req_psum = 1'b0;
    tick();
    check("b2b_vld1",  bus.o_psum_vld, 1);
    check("b2b_data1", bus.o_psum_data, 32'hAA);
    tick();
    check("b2b_vld_end", bus.o_psum_vld, 0);

    // drain len 8 with toggling ready and a PE access mid-drain
    for (int i = 0; i < 8; i++) wr(AW'(i), W'(i + 1));
    bus.i_drain_start = 1'b1;
    bus.i_drain_len   = 13'd8;
    tick();
    bus.i_drain_start = 1'b0;
    check("drain_busy",    bus.o_busy, 1);
    check("drain_vld_1st", bus.o_drain_vld, 0);
    idx = 0; dones = 0; cyc = 0; rdy = 1'b1; stall_prev = 1'b0; pe_seen = 1'b0;
    prev_addr = '0; prev_data = '0;
    while (idx < 8 && cyc < 60) begin
      if (bus.o_psum_vld)   pe_seen = 1'b1;
      if (bus.o_drain_done) dones++;
      if (stall_prev) begin
        check("drain_hold_vld",  bus.o_drain_vld, 1);
        check("drain_hold_addr", bus.o_drain_addr, prev_addr);
        check("drain_hold_data", bus.o_drain_data, prev_data);
      end
      bus.i_drain_ready = rdy;
      if (cyc == 1) begin
        bus.i_req_psum   = 1'b1;
        bus.i_rd_addr    = 12'd0;
        bus.i_psum_we    = 1'b1;
        bus.i_psum_addr  = 12'd7;
        bus.i_psum_wdata = 32'hDEAD;
      end else begin
        bus.i_req_psum = 1'b0;
        bus.i_psum_we  = 1'b0;
      end
      if (bus.o_drain_vld && rdy) begin
        check("drain_addr", bus.o_drain_addr, idx);
        check("drain_data", bus.o_drain_data, idx + 1);
        idx++;
      end
      stall_prev = bus.o_drain_vld && !rdy;
      prev_addr  = bus.o_drain_addr;
      prev_data  = bus.o_drain_data;
      rdy = ~rdy;
      cyc++;
      tick();
    end
    check("drain_count", idx, 8);
    bus.i_drain_ready = 1'b0;
    if (bus.o_drain_done) dones++;
    check("drain_done_pulse", bus.o_drain_done, 1);
    if (bus.o_psum_vld) pe_seen = 1'b1;
    tick();
    if (bus.o_psum_vld) pe_seen = 1'b1;
    check("drain_done_low", bus.o_drain_done, 0);
    check("drain_busy_low", bus.o_busy, 0);
    check("drain_vld_low",  bus.o_drain_vld, 0);
    check("drain_dones",    dones, 1);
    check("drain_no_pe_rd", pe_seen, 0);
    check("drain_err",      bus.o_err, 1);
    for (int i = 0; i < 8; i++) rd(AW'(i), 1'b0, 32'h0, "post_drain");
    check("err_sticky", bus.o_err, 1);

    // zero-length drain
    bus.i_drain_start = 1'b1;
    bus.i_drain_len   = '0;
    tick();
    bus.i_drain_start = 1'b0;
    check("len0_done", bus.o_drain_done, 1);
    check("len0_busy", bus.o_busy, 0);
    tick();
    check("len0_done_low", bus.o_drain_done, 0);

    // reset after three drain handshakes
    for (int i = 0; i < 8; i++) wr(AW'(i), W'(32'h100 + i));
    bus.i_drain_start = 1'b1;
    bus.i_drain_len   = 13'd8;
    bus.i_drain_ready = 1'b1;
    tick();
    bus.i_drain_start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 3 && cyc < 40) begin
      if (bus.o_drain_vld) hs++;
      cyc++;
      if (hs < 3) tick();
    end
    check("abort_hs", hs, 3);
    @(posedge clk);
    #1 rstn = 1'b0;
    bus.i_drain_ready = 1'b0;
    #1 check_reset_outputs("abort");
    tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) rd(AW'(i), 1'b0, 32'h0, "abort_drained");
    for (int i = 3; i < 8; i++) rd(AW'(i), 1'b0, W'(32'h100 + i), "abort_kept");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
